// File: rtl/npc_pkg.sv
// npc_pkg: shared constants and types for the NPC commit/register-file slice.
//   XLEN      register and PC width
//   NR_GPR    architectural register count (index width GPR_IDX_W)
//   RESET_PC  commit_pc value out of reset
//   gpr_idx_t       register index type
//   commit_state_e  commit FSM states
package npc_pkg;
  localparam int              XLEN      = 64;
  localparam int              NR_GPR    = 32;
  localparam int              GPR_IDX_W = 5;
  localparam logic [XLEN-1:0] RESET_PC  = 64'h8000_0000;

  typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } commit_state_e;
endpackage

// File: rtl/gpr_array.sv
// gpr_array: 32 x XLEN register storage with x0 hardwired to zero, two
// combinational read ports and a flattened view of all registers.
// Optional macro GPR_BYPASS_EN: read ports forward wr_data when the same
// non-zero index is being written this cycle.
//   clock, reset        rising-edge clock, async active-high reset
//   wr_en/wr_addr/wr_data  write port (writes to index 0 are dropped)
//   rs1_addr/rs2_addr   read indices; rs1_data/rs2_data read values
//   rf_flat             register i at [i*XLEN +: XLEN]
module gpr_array
  import npc_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  gpr_idx_t               wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  gpr_idx_t               rs1_addr,
  input  gpr_idx_t               rs2_addr,
  output logic [XLEN-1:0]        rs1_data,
  output logic [XLEN-1:0]        rs2_data,
  output logic [NR_GPR*XLEN-1:0] rf_flat
);

  logic [XLEN-1:0] regs_q [NR_GPR];
  logic [XLEN-1:0] regs_d [NR_GPR];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != '0)) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef GPR_BYPASS_EN
    if (wr_en && (wr_addr != '0) && (wr_addr == rs1_addr)) rs1_data = wr_data;
    if (wr_en && (wr_addr != '0) && (wr_addr == rs2_addr)) rs2_data = wr_data;
`endif
  end

  always_comb begin
    rf_flat = '0;
    for (int i = 1; i < NR_GPR; i++) rf_flat[i*XLEN +: XLEN] = regs_q[i];
  end

endmodule

// File: rtl/gpr_commit_file.sv
// gpr_commit_file: architectural GPR file plus registered commit snapshot
// (commit_pc, instret, commit_valid pulse, halted) for the trace stage.
// Optional macro GPR_BYPASS_EN enables write-to-read forwarding (see gpr_array).
//   clock, reset                 rising-edge clock, async active-high reset
//   rs1/rs2_addr, rs1/rs2_data   combinational read ports
//   wb_valid/rd/wen/data/pc/halt write-back commit request
//   commit_valid, commit_pc, instret, halted  registered snapshot
//   rf_flat                      all registers, slice 0 always 0
//
// state | meaning
// RUN   | commits accepted when wb_valid=1
// HALT  | halt committed; wb_* ignored until reset
module gpr_commit_file
  import npc_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  gpr_idx_t               rs1_addr,
  input  gpr_idx_t               rs2_addr,
  output logic [XLEN-1:0]        rs1_data,
  output logic [XLEN-1:0]        rs2_data,
  input  logic                   wb_valid,
  input  gpr_idx_t               wb_rd,
  input  logic                   wb_wen,
  input  logic [XLEN-1:0]        wb_data,
  input  logic [XLEN-1:0]        wb_pc,
  input  logic                   wb_halt,
  output logic                   commit_valid,
  output logic [XLEN-1:0]        commit_pc,
  output logic [63:0]            instret,
  output logic                   halted,
  output logic [NR_GPR*XLEN-1:0] rf_flat
);

  commit_state_e   state_q, state_d;
  logic [XLEN-1:0] commit_pc_q, commit_pc_d;
  logic [63:0]     instret_q, instret_d;
  logic            commit_valid_q, commit_valid_d;
  logic            halted_q, halted_d;
  logic            wb_accept;

  assign wb_accept = wb_valid && (state_q == RUN);

  gpr_array u_gpr_array (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wb_accept && wb_wen),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rf_flat  (rf_flat)
  );

  always_comb begin
    state_d        = state_q;
    commit_pc_d    = commit_pc_q;
    instret_d      = instret_q;
    commit_valid_d = 1'b0;
    if (wb_accept) begin
      commit_pc_d    = wb_pc;
      instret_d      = instret_q + 64'd1;
      commit_valid_d = 1'b1;
      if (wb_halt) state_d = HALT;
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      commit_pc_q    <= RESET_PC;
      instret_q      <= '0;
      commit_valid_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      commit_pc_q    <= commit_pc_d;
      instret_q      <= instret_d;
      commit_valid_q <= commit_valid_d;
      halted_q       <= halted_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign instret      = instret_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_gpr_commit_file.sv
module tb_gpr_commit_file;
  import npc_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [4:0]             rs1_addr = '0, rs2_addr = '0;
  logic [63:0]            rs1_data, rs2_data;
  logic                   wb_valid = 1'b0;
  logic [4:0]             wb_rd = '0;
  logic                   wb_wen = 1'b0;
  logic [63:0]            wb_data = '0, wb_pc = '0;
  logic                   wb_halt = 1'b0;
  logic                   commit_valid;
  logic [63:0]            commit_pc, instret;
  logic                   halted;
  logic [32*64-1:0]       rf_flat;

  gpr_commit_file dut (
    .clock(clock), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .wb_data(wb_data), .wb_pc(wb_pc), .wb_halt(wb_halt),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .instret(instret), .halted(halted), .rf_flat(rf_flat)
  );

  always #5 clock = ~clock;

  // Reference model: architectural view only.
  logic [63:0] m_rf [32];
  logic [63:0] m_pc, m_instret;
  logic        m_halted, m_cv;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc = 64'h8000_0000; m_instret = '0; m_halted = 1'b0; m_cv = 1'b0;
  endtask

  function automatic logic [63:0] exp_read(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef GPR_BYPASS_EN
    if (wb_valid && wb_wen && !m_halted && wb_rd == a) return wb_data;
`endif
    return m_rf[a];
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".commit_valid"}, {63'd0, commit_valid}, {63'd0, m_cv});
    check({tag, ".commit_pc"}, commit_pc, m_pc);
    check({tag, ".instret"}, instret, m_instret);
    check({tag, ".halted"}, {63'd0, halted}, {63'd0, m_halted});
    for (int i = 0; i < 32; i++)
      check($sformatf("%s.rf_flat[%0d]", tag, i), rf_flat[i*64 +: 64], m_rf[i]);
  endtask

  // Called right after a negedge: drive, check reads, clock, check snapshot.
  task automatic step(input string tag, input logic v, input logic [4:0] rd, input logic wen,
                      input logic [63:0] data, input logic [63:0] pc, input logic hlt,
                      input logic [4:0] a1, input logic [4:0] a2);
    wb_valid = v; wb_rd = rd; wb_wen = wen; wb_data = data; wb_pc = pc; wb_halt = hlt;
    rs1_addr = a1; rs2_addr = a2;
    #1;
    check({tag, ".rs1"}, rs1_data, exp_read(a1));
    check({tag, ".rs2"}, rs2_data, exp_read(a2));
    @(posedge clock);
    if (v && !m_halted) begin
      if (wen && rd != 0) m_rf[rd] = data;
      m_pc = pc; m_instret = m_instret + 64'd1; m_cv = 1'b1;
      if (hlt) m_halted = 1'b1;
    end else begin
      m_cv = 1'b0;
    end
    @(negedge clock);
    check_state(tag);
  endtask

  task automatic rand_step(input string tag, input int halt_odds);
    step(tag, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom_range(0, 1) != 0,
         {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(1, halt_odds) == 1),
         5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  // Async reset asserted mid-cycle with a commit pending; it must be lost.
  task automatic async_reset(input string tag);
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 64'hBAD; wb_pc = 64'h1;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_state({tag, ".async"});
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    wb_valid = 1'b0;
    #1;
    check_state({tag, ".held"});
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_state("reset");
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #0.1;
      check($sformatf("reset.rs1[%0d]", i), rs1_data, 64'd0);
      check($sformatf("reset.rs2[%0d]", 31 - i), rs2_data, 64'd0);
    end
    @(negedge clock);

    step("w5", 1, 5, 1, 64'hDEAD_BEEF, 64'h8000_0004, 0, 5, 0);
    step("rd5", 0, 0, 0, 0, 0, 0, 5, 5);
    step("x0", 1, 0, 1, 64'h1234, 64'h8000_0008, 0, 0, 5);
    step("rdx0", 0, 0, 0, 0, 0, 0, 0, 0);
    step("b2b0", 1, 1, 1, 64'hA1, 64'h8000_0010, 0, 1, 2);
    step("b2b1", 1, 2, 1, 64'hA2, 64'h8000_0014, 0, 1, 2);
    step("b2b2", 1, 3, 0, 64'hA3, 64'h8000_0018, 0, 2, 3);
    step("w7", 1, 7, 1, 64'h11, 64'h8000_001C, 0, 0, 0);
    step("rdw7", 1, 7, 1, 64'h55, 64'h8000_0020, 0, 7, 7);
    step("rd7", 0, 0, 0, 0, 0, 0, 7, 0);

    for (int i = 0; i < 150; i++) rand_step("rnd", 1000);

    step("halt", 1, 12, 1, 64'hC0FFEE, 64'h8000_1000, 1, 12, 0);
    for (int i = 0; i < 20; i++) rand_step("halted", 2);

    async_reset("rst1");
    for (int i = 0; i < 120; i++) rand_step("rnd2", 40);

    async_reset("rst2");
    for (int i = 0; i < 40; i++) rand_step("rnd3", 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
